// File: rtl/usb_rx_data_strip.sv
// USB RX data-phase stage: checks PID and CRC16, withholds the two trailing CRC
// bytes through a two-deep hold line and forwards payload bytes with a per-packet status pulse.
module usb_rx_data_strip #(
  parameter int unsigned MAX_PAYLOAD = 1023,
  parameter int unsigned LEN_W       = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [3:0]       out_pid,
  output logic             st_valid,
  output logic             st_crc_ok,
  output logic             st_pid_err,
  output logic             st_len_err,
  output logic             st_zlp,
  output logic [LEN_W-1:0] st_len
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_STREAM
  } state_t;

  state_t           r_state;
  logic [7:0]       r_h0;
  logic [7:0]       r_h1;
  logic [1:0]       r_hold_cnt;
  logic [15:0]      r_crc;
  logic [LEN_W-1:0] r_cnt;
  logic             r_first;
  logic             r_pid_err;

  logic             w_acc;
  logic             w_pid_bad;
  logic [15:0]      w_crc_next;
  logic [LEN_W:0]   w_cnt_inc;
  logic [LEN_W-1:0] w_cnt_sat;
  logic             w_too_long;

  // Reflected CRC16 (poly 0xA001), data consumed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] x;
    x = c;
    for (int unsigned i = 0; i < 8; i++) begin
      if (x[0] ^ d[i]) x = (x >> 1) ^ 16'hA001;
      else             x = x >> 1;
    end
    return x;
  endfunction

  assign in_ready   = !rst && (!out_valid || out_ready);
  assign w_acc      = in_valid && in_ready;
  assign w_pid_bad  = (in_data[7:4] != ~in_data[3:0]);
  assign w_crc_next = crc16_byte(r_crc, in_data);
  assign w_cnt_inc  = {1'b0, r_cnt} + {{LEN_W{1'b0}}, 1'b1};
  assign w_cnt_sat  = w_cnt_inc[LEN_W] ? '1 : w_cnt_inc[LEN_W-1:0];
  assign w_too_long = (32'(w_cnt_inc) > MAX_PAYLOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_h0       <= '0;
      r_h1       <= '0;
      r_hold_cnt <= '0;
      r_crc      <= '1;
      r_cnt      <= '0;
      r_first    <= 1'b0;
      r_pid_err  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_pid    <= '0;
      st_valid   <= 1'b0;
      st_crc_ok  <= 1'b0;
      st_pid_err <= 1'b0;
      st_len_err <= 1'b0;
      st_zlp     <= 1'b0;
      st_len     <= '0;
    end else begin
      st_valid   <= 1'b0;
      st_crc_ok  <= 1'b0;
      st_pid_err <= 1'b0;
      st_len_err <= 1'b0;
      st_zlp     <= 1'b0;
      st_len     <= '0;
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (w_acc) begin
        if (in_sop) begin
          // An SOP mid-packet closes the old packet as a length error; held bytes are dropped.
          if (r_state != S_IDLE) begin
            st_valid   <= 1'b1;
            st_len_err <= 1'b1;
            st_pid_err <= r_pid_err;
            st_len     <= r_cnt;
          end
          out_pid    <= in_data[3:0];
          r_pid_err  <= w_pid_bad;
          r_crc      <= '1;
          r_hold_cnt <= '0;
          r_cnt      <= '0;
          r_first    <= 1'b1;
          if (in_eop) begin
            st_valid   <= 1'b1;
            st_len_err <= 1'b1;
            st_pid_err <= w_pid_bad;
            st_len     <= '0;
            r_state    <= S_IDLE;
          end else begin
            r_state    <= S_FILL;
          end
        end else if (r_state != S_IDLE) begin
          r_crc <= w_crc_next;
          if (r_hold_cnt == 2'd2) begin
            out_valid <= 1'b1;
            out_data  <= r_h0;
            out_sop   <= r_first;
            out_eop   <= in_eop;
            r_first   <= 1'b0;
            r_cnt     <= w_cnt_sat;
            r_h0      <= r_h1;
            r_h1      <= in_data;
          end else if (r_hold_cnt == 2'd1) begin
            r_h1       <= in_data;
            r_hold_cnt <= 2'd2;
            r_state    <= S_STREAM;
          end else begin
            r_h0       <= in_data;
            r_hold_cnt <= 2'd1;
          end

          if (in_eop) begin
            st_valid   <= 1'b1;
            st_pid_err <= r_pid_err;
            r_state    <= S_IDLE;
            r_hold_cnt <= '0;
            case (r_hold_cnt)
              2'd0: st_len_err <= 1'b1;
              2'd1: begin
                st_zlp    <= 1'b1;
                st_crc_ok <= (w_crc_next == 16'hB001);
              end
              default: begin
                st_crc_ok  <= (w_crc_next == 16'hB001);
                st_len     <= w_cnt_sat;
                st_len_err <= w_too_long;
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_data_strip.sv
// Scoreboard bench for usb_rx_data_strip: expected payload bytes and status
// words are queued as packets are built and popped as the DUT produces them.
module tb_usb_rx_data_strip;
  localparam int unsigned LEN_W = 11;
  localparam int unsigned MAXP  = 1023;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_sop, in_eop, in_valid, in_ready;
  logic [7:0]       in_data;
  logic             out_sop, out_eop, out_valid, out_ready;
  logic [7:0]       out_data;
  logic [3:0]       out_pid;
  logic             st_valid, st_crc_ok, st_pid_err, st_len_err, st_zlp;
  logic [LEN_W-1:0] st_len;

  int checks = 0;
  int errors = 0;

  logic [9:0]       outq[$];
  logic [LEN_W+3:0] stq[$];
  logic [7:0]       pay[$];
  logic [7:0]       pkt[$];
  logic [9:0]       mon_out;
  logic [LEN_W+3:0] mon_st;
  bit               bp_en = 1'b0;
  int unsigned      cyc = 0;

  usb_rx_data_strip #(.MAX_PAYLOAD(MAXP), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .in_sop(in_sop), .in_eop(in_eop), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_sop(out_sop), .out_eop(out_eop), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_pid(out_pid), .st_valid(st_valid), .st_crc_ok(st_crc_ok), .st_pid_err(st_pid_err),
    .st_len_err(st_len_err), .st_zlp(st_zlp), .st_len(st_len)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (bp_en) out_ready = ((cyc % 3) == 0);
  end

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      checks++;
      if (outq.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected got sop=%b eop=%b data=%h", out_sop, out_eop, out_data);
      end else begin
        mon_out = outq.pop_front();
        if ({out_sop, out_eop, out_data} !== mon_out) begin
          errors++;
          $display("FAIL out_byte got {sop,eop,data}=%h expected %h", {out_sop, out_eop, out_data}, mon_out);
        end
      end
    end
    if (out_valid && !out_ready) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL in_ready_full got %b expected 0", in_ready);
      end
    end
    if (st_valid) begin
      checks++;
      if (stq.size() == 0) begin
        errors++;
        $display("FAIL st_unexpected got crc=%b pid=%b len_err=%b zlp=%b len=%0d",
                 st_crc_ok, st_pid_err, st_len_err, st_zlp, st_len);
      end else begin
        mon_st = stq.pop_front();
        if ({st_crc_ok, st_pid_err, st_len_err, st_zlp, st_len} !== mon_st) begin
          errors++;
          $display("FAIL status got {crc,pid,len_err,zlp,len}=%h expected %h",
                   {st_crc_ok, st_pid_err, st_len_err, st_zlp, st_len}, mon_st);
        end
      end
    end
  end

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] x;
    x = c;
    for (int i = 0; i < 8; i++) x = (x[0] ^ d[i]) ? ((x >> 1) ^ 16'hA001) : (x >> 1);
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic s, input logic e, input logic chkst);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e;
    while (!acc && n < 100) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      step();
      n++;
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got no accept expected accept data=%h", d);
    end else if (chkst) begin
      checks++;
      if (st_valid !== 1'b1) begin
        errors++;
        $display("FAIL st_pulse_timing got %b expected 1", st_valid);
      end
    end
  endtask

  // Builds pid + pay + CRC16 into pkt and queues the expected outputs and status.
  task automatic make_pkt(input logic [7:0] pid, input bit corrupt);
    logic [15:0]      c;
    logic [7:0]       b;
    logic [LEN_W-1:0] ln;
    int               n;
    n = pay.size();
    ln = n[LEN_W-1:0];
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) c = crc_upd(c, pay[i]);
    c = ~c;
    pkt.delete();
    pkt.push_back(pid);
    for (int i = 0; i < n; i++) begin
      b = pay[i];
      if (corrupt && i == n - 1) b = b ^ 8'h04;
      pkt.push_back(b);
      outq.push_back({i == 0, i == n - 1, b});
    end
    pkt.push_back(c[7:0]);
    pkt.push_back(c[15:8]);
    stq.push_back({!corrupt, pid[7:4] != ~pid[3:0], n > int'(MAXP), n == 0, ln});
  endtask

  task automatic send_pkt();
    for (int i = 0; i < pkt.size(); i++)
      send_byte(pkt[i], i == 0, i == pkt.size() - 1, i == pkt.size() - 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((outq.size() != 0 || stq.size() != 0) && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (outq.size() != 0 || stq.size() != 0) begin
      errors++;
      $display("FAIL drain got out=%0d st=%0d pending expected 0", outq.size(), stq.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({in_ready, out_valid, out_sop, out_eop, out_data, out_pid, st_valid, st_len} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b ov=%b pid=%h sv=%b expected all 0", in_ready, out_valid, out_pid, st_valid);
    end
    rst = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b expected 1", in_ready);
    end
  endtask

  task automatic test_zlp();
    pay.delete();
    make_pkt(8'hC3, 1'b0);
    send_pkt();
    wait_drain();
    checks++;
    if (out_pid !== 4'h3) begin
      errors++;
      $display("FAIL zlp_pid got %h expected 3", out_pid);
    end
  endtask

  task automatic test_data1();
    pay = '{8'h00, 8'h01, 8'h02, 8'h03};
    make_pkt(8'h4B, 1'b0);
    send_pkt();
    wait_drain();
    checks++;
    if (out_pid !== 4'hB) begin
      errors++;
      $display("FAIL data1_pid got %h expected b", out_pid);
    end
    make_pkt(8'h4B, 1'b1);
    send_pkt();
    wait_drain();
  endtask

  task automatic test_backpressure();
    pay = '{8'h00, 8'h01, 8'h02, 8'h03};
    make_pkt(8'h4B, 1'b0);
    bp_en = 1'b1;
    send_pkt();
    wait_drain();
    bp_en = 1'b0;
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_short_bad();
    stq.push_back({1'b0, 1'b0, 1'b1, 1'b0, {LEN_W{1'b0}}});
    send_byte(8'hC3, 1'b1, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b1, 1'b1);
    stq.push_back({1'b0, 1'b0, 1'b1, 1'b0, {LEN_W{1'b0}}});
    send_byte(8'hD2, 1'b1, 1'b1, 1'b1);
    wait_drain();
    pay.delete();
    make_pkt(8'h33, 1'b0);
    send_pkt();
    wait_drain();
  endtask

  task automatic test_abort();
    outq.push_back({1'b1, 1'b0, 8'h11});
    send_byte(8'hC3, 1'b1, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0, 1'b0);
    stq.push_back({1'b0, 1'b0, 1'b1, 1'b0, 11'd1});
    send_byte(8'h4B, 1'b1, 1'b0, 1'b1);
    stq.push_back({1'b1, 1'b0, 1'b0, 1'b1, 11'd0});
    send_byte(8'h00, 1'b0, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b1, 1'b1);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    pay = '{8'hA5, 8'h5A, 8'hFF};
    make_pkt(8'hC3, 1'b0);
    send_pkt();
    pay = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    make_pkt(8'h4B, 1'b0);
    send_pkt();
    pay = '{8'h7E};
    make_pkt(8'hC3, 1'b0);
    send_pkt();
    wait_drain();
  endtask

  task automatic test_max_len();
    pay.delete();
    for (int i = 0; i < int'(MAXP); i++) pay.push_back(8'(i * 7 + 3));
    make_pkt(8'hC3, 1'b0);
    send_pkt();
    wait_drain();
    pay.push_back(8'h99);
    make_pkt(8'h4B, 1'b0);
    send_pkt();
    wait_drain();
  endtask

  task automatic test_reset_mid();
    send_byte(8'hC3, 1'b1, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    checks++;
    if ({in_ready, out_valid, out_sop, out_eop, out_data, out_pid, st_valid, st_crc_ok,
         st_pid_err, st_len_err, st_zlp, st_len} !== '0) begin
      errors++;
      $display("FAIL reset_mid got ov=%b pid=%h sv=%b expected all 0", out_valid, out_pid, st_valid);
    end
    rst = 1'b0;
    step();
    pay.delete();
    make_pkt(8'hC3, 1'b0);
    send_pkt();
    wait_drain();
  endtask

  initial begin
    rst = 1'b1;
    in_sop = 1'b0; in_eop = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1;
    test_reset();
    test_zlp();
    test_data1();
    test_backpressure();
    test_short_bad();
    test_abort();
    test_back_to_back();
    test_max_len();
    test_reset_mid();
    repeat (5) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
